// File: rtl/exc_seq_ctrl_if.sv
// rtl/exc_seq_ctrl_if.sv - decode/CP0 bundle for the exception sequencing controller
// Purpose: groups the op handshake, CP0 access, redirect/flush and mfc0 return signals.
// Modports:
//   master - decode stage and CP0 side: drives op handshake inputs, cp0_rdata, cp0_exc_addr
//   slave  - exc_seq_ctrl: drives inst_ready, cp0_* requests, redirect/flush, mfc0 return, status
interface exc_seq_ctrl_if;
  logic        inst_valid;
  logic        inst_ready;
  logic [2:0]  op;
  logic        teq_eq;
  logic [31:0] inst_pc;
  logic [4:0]  addr_in;
  logic [31:0] wdata_in;
  logic [3:0]  cp0_choice;
  logic [3:0]  cp0_cause;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_pc;
  logic [31:0] cp0_rdata;
  logic [31:0] cp0_exc_addr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        mfc0_valid;
  logic [31:0] mfc0_data;
  logic [7:0]  exc_count;
  logic        busy;

  modport master (
    output inst_valid, op, teq_eq, inst_pc, addr_in, wdata_in, cp0_rdata, cp0_exc_addr,
    input  inst_ready, cp0_choice, cp0_cause, cp0_addr, cp0_wdata, cp0_pc,
           redirect, redirect_pc, flush, mfc0_valid, mfc0_data, exc_count, busy
  );

  modport slave (
    input  inst_valid, op, teq_eq, inst_pc, addr_in, wdata_in, cp0_rdata, cp0_exc_addr,
    output inst_ready, cp0_choice, cp0_cause, cp0_addr, cp0_wdata, cp0_pc,
           redirect, redirect_pc, flush, mfc0_valid, mfc0_data, exc_count, busy
  );
endinterface

// File: rtl/exc_seq_ctrl.sv
// rtl/exc_seq_ctrl.sv - exception / eret / mtc0 / mfc0 sequencing controller
// Purpose: accepts one CP0-related op at a time from decode, sequences the CP0
//   request, the fetch redirect and pipeline flush, and returns mfc0 read data.
// Ports:
//   clk - clock, all state updates on its rising edge
//   rst - asynchronous active-low reset
//   bus - exc_seq_ctrl_if.slave: op handshake in, CP0 request/response,
//         redirect/flush strobes, mfc0 return, exception counter, busy
module exc_seq_ctrl #(
  parameter logic [3:0] SYSCALL = 4'b1000,
  parameter logic [3:0] BREAK   = 4'b1001,
  parameter logic [3:0] TEQ     = 4'b1101
) (
  input logic           clk,
  input logic           rst,
  exc_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXC  = 3'd1,
    S_VEC  = 3'd2,
    S_ERET = 3'd3,
    S_MTC0 = 3'd4,
    S_MFC0 = 3'd5
  } state_t;

  localparam logic [2:0] OP_SYSCALL = 3'b001;
  localparam logic [2:0] OP_BREAK   = 3'b010;
  localparam logic [2:0] OP_TEQ     = 3'b011;
  localparam logic [2:0] OP_ERET    = 3'b100;
  localparam logic [2:0] OP_MTC0    = 3'b101;
  localparam logic [2:0] OP_MFC0    = 3'b110;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic        teq_eq_q, teq_eq_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  exc_count_q, exc_count_d;
  logic [31:0] mfc0_data_q, mfc0_data_d;
  logic        mfc0_valid_q, mfc0_valid_d;

  logic        accept;
  logic [3:0]  choice;
  logic [3:0]  cause;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_pc;
  logic        redirect;
  logic        flush;
  logic [31:0] redirect_pc;

  assign accept = bus.inst_valid && (state_q == S_IDLE);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    teq_eq_d     = teq_eq_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    exc_count_d  = exc_count_q;
    mfc0_data_d  = mfc0_data_q;
    mfc0_valid_d = 1'b0;
    choice       = 4'b0000;
    cause        = 4'b0000;
    cp0_addr     = 5'd0;
    cp0_wdata    = 32'd0;
    cp0_pc       = 32'd0;
    redirect     = 1'b0;
    flush        = 1'b0;
    redirect_pc  = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d     = bus.op;
          teq_eq_d = bus.teq_eq;
          pc_d     = bus.inst_pc;
          addr_d   = bus.addr_in;
          wdata_d  = bus.wdata_in;
          case (bus.op)
            OP_SYSCALL, OP_BREAK: state_d = S_EXC;
            // A teq that does not trap is consumed here with no CP0 activity.
            OP_TEQ:               state_d = bus.teq_eq ? S_EXC : S_IDLE;
            OP_ERET:              state_d = S_ERET;
            OP_MTC0:              state_d = S_MTC0;
            OP_MFC0:              state_d = S_MFC0;
            default:              state_d = S_IDLE;
          endcase
        end
      end
      S_EXC: begin
        choice = {teq_eq_q && (op_q == OP_TEQ), 3'b000};
        case (op_q)
          OP_SYSCALL: cause = SYSCALL;
          OP_BREAK:   cause = BREAK;
          OP_TEQ:     cause = TEQ;
          default:    cause = 4'b0000;
        endcase
        cp0_pc = pc_q;
        // Counter is bumped on entry to VEC so it already reads the new
        // value while the redirect strobe is up.
        if (exc_count_q != 8'hFF) begin
          exc_count_d = exc_count_q + 8'd1;
        end
        state_d = S_VEC;
      end
      S_VEC: begin
        redirect    = 1'b1;
        flush       = 1'b1;
        redirect_pc = bus.cp0_exc_addr;
        state_d     = S_IDLE;
      end
      S_ERET: begin
        choice      = 4'b0100;
        redirect    = 1'b1;
        flush       = 1'b1;
        redirect_pc = bus.cp0_exc_addr;
        state_d     = S_IDLE;
      end
      S_MTC0: begin
        choice    = 4'b0010;
        cp0_addr  = addr_q;
        cp0_wdata = wdata_q;
        state_d   = S_IDLE;
      end
      S_MFC0: begin
        choice       = 4'b0001;
        cp0_addr     = addr_q;
        mfc0_data_d  = bus.cp0_rdata;
        mfc0_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      op_q         <= 3'd0;
      teq_eq_q     <= 1'b0;
      pc_q         <= 32'd0;
      addr_q       <= 5'd0;
      wdata_q      <= 32'd0;
      exc_count_q  <= 8'd0;
      mfc0_data_q  <= 32'd0;
      mfc0_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      teq_eq_q     <= teq_eq_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      exc_count_q  <= exc_count_d;
      mfc0_data_q  <= mfc0_data_d;
      mfc0_valid_q <= mfc0_valid_d;
    end
  end

  assign bus.inst_ready  = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.cp0_choice  = choice;
  assign bus.cp0_cause   = cause;
  assign bus.cp0_addr    = cp0_addr;
  assign bus.cp0_wdata   = cp0_wdata;
  assign bus.cp0_pc      = cp0_pc;
  assign bus.redirect    = redirect;
  assign bus.flush       = flush;
  assign bus.redirect_pc = redirect_pc;
  assign bus.mfc0_valid  = mfc0_valid_q;
  assign bus.mfc0_data   = mfc0_data_q;
  assign bus.exc_count   = exc_count_q;

endmodule

// File: tb/tb_exc_seq_ctrl.sv
// tb/tb_exc_seq_ctrl.sv - scoreboard bench for exc_seq_ctrl
module tb_exc_seq_ctrl;
  localparam int MAXC = 8192;

  typedef enum int {K_EXC, K_VEC, K_ERET, K_MTC0, K_MFC0, K_MVALID} kind_t;
  typedef struct {
    int          cyc;
    kind_t       kind;
    logic [3:0]  choice;
    logic [3:0]  cause;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [7:0]  cnt;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  ev_t         exp_q[$];
  logic [31:0] rdata_hist[MAXC];
  logic [31:0] ea_hist[MAXC];
  bit          ready_hist[MAXC];
  int          free_cyc = 0;
  int          model_cnt = 0;

  logic        mon_act;
  ev_t         mon_e;

  exc_seq_ctrl_if bus();

  exc_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [3:0] cause_of(input logic [2:0] o);
    case (o)
      3'd1:    return 4'b1000;
      3'd2:    return 4'b1001;
      3'd3:    return 4'b1101;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic void push(input int c, input kind_t k, input logic [3:0] ch,
                               input logic [3:0] ca, input logic [4:0] a,
                               input logic [31:0] w, input logic [31:0] p, input int cnt);
    ev_t e;
    e.cyc = c; e.kind = k; e.choice = ch; e.cause = ca;
    e.addr = a; e.wdata = w; e.pc = p; e.cnt = cnt[7:0];
    exp_q.push_back(e);
  endfunction

  // Reference model: an op accepted at the edge ending cycle c occupies the
  // following cycles; free_cyc is the first cycle in which a new op is taken.
  function automatic void model_accept(input int c, input logic [2:0] o, input bit eq,
                                       input logic [31:0] pc, input logic [4:0] a,
                                       input logic [31:0] wd);
    case (o)
      3'd1, 3'd2, 3'd3: begin
        if (o != 3'd3 || eq) begin
          push(c + 1, K_EXC, (o == 3'd3) ? 4'b1000 : 4'b0000, cause_of(o), 5'd0, 32'd0, pc, model_cnt);
          if (model_cnt < 255) model_cnt++;
          push(c + 2, K_VEC, 4'd0, 4'd0, 5'd0, 32'd0, 32'd0, model_cnt);
          free_cyc = c + 3;
        end else begin
          free_cyc = c + 1;
        end
      end
      3'd4: begin
        push(c + 1, K_ERET, 4'b0100, 4'd0, 5'd0, 32'd0, 32'd0, model_cnt);
        free_cyc = c + 2;
      end
      3'd5: begin
        push(c + 1, K_MTC0, 4'b0010, 4'd0, a, wd, 32'd0, model_cnt);
        free_cyc = c + 2;
      end
      3'd6: begin
        push(c + 1, K_MFC0, 4'b0001, 4'd0, a, 32'd0, 32'd0, model_cnt);
        push(c + 2, K_MVALID, 4'd0, 4'd0, 5'd0, 32'd0, 32'd0, model_cnt);
        free_cyc = c + 2;
      end
      default: free_cyc = c + 1;
    endcase
  endfunction

  task automatic drv(input bit v, input logic [2:0] o, input bit eq, input logic [31:0] pc,
                     input logic [4:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input logic [31:0] ea);
    int  c;
    bit  idle;
    @(posedge clk);
    #1;
    c = cyc;
    bus.inst_valid   = v;
    bus.op           = o;
    bus.teq_eq       = eq;
    bus.inst_pc      = pc;
    bus.addr_in      = a;
    bus.wdata_in     = wd;
    bus.cp0_rdata    = rd;
    bus.cp0_exc_addr = ea;
    idle = (c >= free_cyc);
    if (c < MAXC) begin
      rdata_hist[c] = rd;
      ea_hist[c]    = ea;
      ready_hist[c] = idle;
    end
    if (v && idle && rst) model_accept(c, o, eq, pc, a, wd);
  endtask

  task automatic idle_n(input int n, input logic [31:0] ea, input logic [31:0] rd);
    for (int i = 0; i < n; i++) drv(1'b0, 3'd0, 1'b0, 32'd0, 5'd0, 32'd0, rd, ea);
  endtask

  always @(negedge clk) begin
    if (mon_en && rst === 1'b1 && cyc < MAXC) begin
      chk("inst_ready", {31'd0, bus.inst_ready}, {31'd0, ready_hist[cyc]});
      chk("busy", {31'd0, bus.busy}, {31'd0, !ready_hist[cyc]});
      mon_act = (bus.cp0_choice != 4'd0) || (bus.cp0_cause != 4'd0) ||
                bus.redirect || bus.flush || bus.mfc0_valid;
      if (mon_act) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_activity", {31'd0, mon_act}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("event_cycle", cyc, mon_e.cyc);
          chk("redirect", {31'd0, bus.redirect}, {31'd0, mon_e.kind inside {K_VEC, K_ERET}});
          chk("flush", {31'd0, bus.flush}, {31'd0, mon_e.kind inside {K_VEC, K_ERET}});
          chk("mfc0_valid", {31'd0, bus.mfc0_valid}, {31'd0, mon_e.kind == K_MVALID});
          chk("exc_count", {24'd0, bus.exc_count}, {24'd0, mon_e.cnt});
          case (mon_e.kind)
            K_EXC: begin
              chk("exc_choice", {28'd0, bus.cp0_choice}, {28'd0, mon_e.choice});
              chk("exc_cause", {28'd0, bus.cp0_cause}, {28'd0, mon_e.cause});
              chk("exc_pc", bus.cp0_pc, mon_e.pc);
            end
            K_VEC: chk("vec_redirect_pc", bus.redirect_pc, ea_hist[cyc]);
            K_ERET: begin
              chk("eret_choice", {28'd0, bus.cp0_choice}, {28'd0, mon_e.choice});
              chk("eret_redirect_pc", bus.redirect_pc, ea_hist[cyc]);
            end
            K_MTC0: begin
              chk("mtc0_choice", {28'd0, bus.cp0_choice}, {28'd0, mon_e.choice});
              chk("mtc0_addr", {27'd0, bus.cp0_addr}, {27'd0, mon_e.addr});
              chk("mtc0_wdata", bus.cp0_wdata, mon_e.wdata);
            end
            K_MFC0: begin
              chk("mfc0_choice", {28'd0, bus.cp0_choice}, {28'd0, mon_e.choice});
              chk("mfc0_addr", {27'd0, bus.cp0_addr}, {27'd0, mon_e.addr});
            end
            default: begin
              chk("mvalid_choice", {28'd0, bus.cp0_choice}, 32'd0);
              chk("mfc0_data", bus.mfc0_data, rdata_hist[cyc - 1]);
            end
          endcase
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        chk("missing_event", {31'd0, mon_act}, 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.inst_valid = 1'b0; bus.op = 3'd0; bus.teq_eq = 1'b0; bus.inst_pc = 32'd0;
    bus.addr_in = 5'd0; bus.wdata_in = 32'd0; bus.cp0_rdata = 32'd0; bus.cp0_exc_addr = 32'd0;
    idle_n(2, 32'd0, 32'd0);
    mon_en = 1'b1;
    #1;
    chk("rst_exc_count", {24'd0, bus.exc_count}, 32'd0);
    chk("rst_mfc0_data", bus.mfc0_data, 32'd0);
    chk("rst_redirect", {31'd0, bus.redirect}, 32'd0);
    chk("rst_flush", {31'd0, bus.flush}, 32'd0);
    chk("rst_mfc0_valid", {31'd0, bus.mfc0_valid}, 32'd0);
    chk("rst_choice", {28'd0, bus.cp0_choice}, 32'd0);
    chk("rst_cause", {28'd0, bus.cp0_cause}, 32'd0);
    chk("rst_inst_ready", {31'd0, bus.inst_ready}, 32'd1);
    rst = 1'b1;
    idle_n(2, 32'd0, 32'd0);

    // Directed: syscall, teq taken / not taken, mtc0 then mfc0, eret.
    drv(1'b1, 3'd1, 1'b0, 32'h100, 5'd0, 32'd0, 32'd0, 32'h4);
    idle_n(3, 32'h4, 32'd0);
    drv(1'b1, 3'd3, 1'b1, 32'h204, 5'd0, 32'd0, 32'd0, 32'h80);
    idle_n(3, 32'h80, 32'd0);
    drv(1'b1, 3'd3, 1'b0, 32'h208, 5'd0, 32'd0, 32'd0, 32'h80);
    idle_n(2, 32'h80, 32'd0);
    drv(1'b1, 3'd5, 1'b0, 32'd0, 5'd12, 32'hF, 32'd0, 32'd0);
    idle_n(2, 32'd0, 32'd0);
    drv(1'b1, 3'd6, 1'b0, 32'd0, 5'd12, 32'd0, 32'hF, 32'd0);
    idle_n(3, 32'd0, 32'hF);
    drv(1'b1, 3'd4, 1'b0, 32'd0, 5'd0, 32'd0, 32'd0, 32'h100);
    idle_n(2, 32'h100, 32'd0);

    // Back-to-back breaks drive the counter into saturation.
    for (int i = 0; i < 790; i++) drv(1'b1, 3'd2, 1'b0, 32'h300 + i, 5'd0, 32'd0, 32'd0, 32'h180);
    idle_n(3, 32'h180, 32'd0);
    #1;
    chk("exc_count_saturated", {24'd0, bus.exc_count}, 32'hFF);

    // Reset asserted while VEC is driving the redirect.
    drv(1'b1, 3'd1, 1'b0, 32'h400, 5'd0, 32'd0, 32'd0, 32'h80);
    idle_n(2, 32'h80, 32'd0);
    #1;
    chk("vec_redirect_before_reset", {31'd0, bus.redirect}, 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_redirect", {31'd0, bus.redirect}, 32'd0);
    chk("midrst_flush", {31'd0, bus.flush}, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_exc_count", {24'd0, bus.exc_count}, 32'd0);
    chk("midrst_mfc0_data", bus.mfc0_data, 32'd0);
    exp_q.delete();
    model_cnt = 0;
    free_cyc = 0;
    idle_n(2, 32'h80, 32'd0);
    rst = 1'b1;
    idle_n(4, 32'h80, 32'd0);

    // Random ops, including ones presented while busy.
    for (int i = 0; i < 1500; i++) begin
      drv(($urandom % 4) != 0, 3'($urandom % 8), 1'($urandom % 2), $urandom,
          5'($urandom % 32), $urandom, $urandom, $urandom);
    end
    idle_n(5, 32'd0, 32'd0);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("final_exc_count", {24'd0, bus.exc_count}, model_cnt);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
